spi_reg_controller: RTL and testbench

- Frame-level controller sitting between spi_slave and the clock-master register file.
- Turns the byte stream from spi_slave (rx byte, ready pulse, busy level) into register read/write strobes.
- Supplies spi_slave's tx byte so read data shifts out on MISO in the byte after the command.
- Only block that sequences SPI register accesses; the register file decodes addresses.

---
 rtl/spi_reg_controller_pkg.sv | 21 ++
 rtl/spi_reg_controller_if.sv | 16 +
 rtl/spi_reg_controller_addr_counter.sv | 35 +++
 rtl/spi_reg_controller.sv | 147 ++++++++++++++
 tb/tb_spi_reg_controller.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_controller_pkg.sv
// rtl/spi_reg_controller_pkg.sv - shared types and constants for the SPI register controller
// Purpose: frame FSM state encoding, command bit position, invalid-read byte,
//          default register count of the clock-master register file.
// Ports:   none (package).
package spi_reg_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RREQ  = 3'd1,
        S_RWAIT = 3'd2,
        S_RDATA = 3'd3,
        S_WDATA = 3'd4,
        S_WNEXT = 3'd5,
        S_HOLD  = 3'd6
    } state_t;

    localparam int         CMD_RW_BIT        = 7;
    localparam logic [7:0] INVALID_RD_BYTE   = 8'hFF;
    localparam int         DEFAULT_REG_COUNT = 64;

endpackage

// File: rtl/spi_reg_controller_if.sv
// rtl/spi_reg_controller_if.sv - register-file access bus between controller and register file
// Purpose: groups address, write data, strobes and read data.
// Ports:   master (controller): drives addr, wr_data, wr_en, rd_en; samples rd_data.
//          slave (register file): the reverse; rd_data valid 1 cycle after rd_en.
interface spi_reg_controller_if #(
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wr_data;
    logic                  wr_en;
    logic                  rd_en;
    logic [7:0]            rd_data;

    modport master (output addr, output wr_data, output wr_en, output rd_en, input rd_data);
    modport slave  (input addr, input wr_data, input wr_en, input rd_en, output rd_data);
endinterface

// File: rtl/spi_reg_controller_addr_counter.sv
// rtl/spi_reg_controller_addr_counter.sv - loadable wrapping register address with range check
// Purpose: holds the current register address, loads it from the command byte,
//          increments modulo 2^ADDR_WIDTH and flags addresses below REG_COUNT.
// Ports:   i_clk, i_rst_n (async active-low), i_load/i_load_addr (load has priority),
//          i_inc (increment), o_addr (current address), o_in_range (o_addr < REG_COUNT).
module spi_reg_controller_addr_counter
    import spi_reg_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int REG_COUNT  = DEFAULT_REG_COUNT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_in_range
);
    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_addr;
        end else if (i_inc) begin
            // natural overflow gives the wrap from the top address back to 0
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_addr     = r_addr;
    assign o_in_range = (32'(r_addr) < 32'(REG_COUNT));
endmodule

// File: rtl/spi_reg_controller.sv
// rtl/spi_reg_controller.sv - SPI frame to register read/write strobe sequencer
// Purpose: decodes spi_slave byte frames (command byte, then data bytes) into
//          register write/read strobes and supplies the MISO byte for reads.
// Ports:   i_clk, i_rst_n (async active-low); i_spi_data_rx/i_spi_ready/i_spi_busy
//          from spi_slave; o_spi_data_tx to spi_slave; reg_bus (master) to the
//          register file; o_frame_active (registered busy); o_addr_err (sticky per frame).
// Config:  SPI_AUTOINC_EN defined -> address auto-increment bursts;
//          undefined -> one register per frame, extra bytes ignored.
module spi_reg_controller
    import spi_reg_controller_pkg::*;
#(
    parameter int         ADDR_WIDTH = 7,
    parameter int         REG_COUNT  = DEFAULT_REG_COUNT,
    parameter logic [7:0] IDLE_TX    = 8'h00
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_spi_data_rx,
    input  logic                     i_spi_ready,
    input  logic                     i_spi_busy,
    output logic [7:0]               o_spi_data_tx,
    output logic                     o_frame_active,
    output logic                     o_addr_err,
    spi_reg_controller_if.master     reg_bus
);
    state_t                r_state;
    state_t                w_next_state;
    logic                  w_load;
    logic                  w_inc;
    logic                  w_wr_capture;
    logic [7:0]            w_tx_next;
    logic [7:0]            r_spi_data_tx;
    logic [7:0]            r_wr_data;
    logic                  r_frame_active;
    logic                  r_addr_err;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_in_range;
    logic                  w_busy_rise;
    logic                  w_access;

    spi_reg_controller_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_addr_counter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_load_addr (i_spi_data_rx[ADDR_WIDTH-1:0]),
        .i_inc       (w_inc),
        .o_addr      (w_addr),
        .o_in_range  (w_in_range)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_wr_capture = 1'b0;
        w_tx_next    = r_spi_data_tx;
        // deasserted select aborts everything, including a byte that arrives in the same cycle
        if (!i_spi_busy) begin
            w_next_state = S_IDLE;
            w_tx_next    = IDLE_TX;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_spi_ready) begin
                        w_load       = 1'b1;
                        w_next_state = i_spi_data_rx[CMD_RW_BIT] ? S_WDATA : S_RREQ;
                    end
                end
                S_RREQ:  w_next_state = S_RWAIT;
                S_RWAIT: begin
                    w_tx_next    = w_in_range ? reg_bus.rd_data : INVALID_RD_BYTE;
                    w_next_state = S_RDATA;
                end
                S_RDATA: begin
                    if (i_spi_ready) begin
`ifdef SPI_AUTOINC_EN
                        w_inc        = 1'b1;
                        w_next_state = S_RREQ;
`else
                        w_tx_next    = IDLE_TX;
                        w_next_state = S_HOLD;
`endif
                    end
                end
                S_WDATA: begin
                    if (i_spi_ready) begin
                        w_wr_capture = 1'b1;
                        w_next_state = S_WNEXT;
                    end
                end
                S_WNEXT: begin
`ifdef SPI_AUTOINC_EN
                    w_inc        = 1'b1;
                    w_next_state = S_WDATA;
`else
                    w_next_state = S_HOLD;
`endif
                end
                S_HOLD:  w_next_state = S_HOLD;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // an access cycle is S_RREQ (read) or S_WNEXT (write); strobes fire only in range
    assign w_access    = (r_state == S_RREQ) || (r_state == S_WNEXT);
    assign w_busy_rise = i_spi_busy && !r_frame_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_spi_data_tx  <= IDLE_TX;
            r_wr_data      <= 8'h00;
            r_frame_active <= 1'b0;
            r_addr_err     <= 1'b0;
        end else begin
            r_spi_data_tx  <= w_tx_next;
            r_frame_active <= i_spi_busy;
            if (w_wr_capture) begin
                r_wr_data <= i_spi_data_rx;
            end
            if (w_busy_rise) begin
                r_addr_err <= 1'b0;
            end else if (w_access && !w_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign reg_bus.addr    = w_addr;
    assign reg_bus.wr_data = r_wr_data;
    assign reg_bus.rd_en   = (r_state == S_RREQ)  && w_in_range;
    assign reg_bus.wr_en   = (r_state == S_WNEXT) && w_in_range;
    assign o_spi_data_tx   = r_spi_data_tx;
    assign o_frame_active  = r_frame_active;
    assign o_addr_err      = r_addr_err;
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb/tb_spi_reg_controller.sv - self-checking bench for spi_reg_controller
module tb_spi_reg_controller;
    localparam int         RC   = 64;
    localparam logic [7:0] IDLE = 8'h00;
    localparam int         GAP  = 10;
`ifdef SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx;
    logic       ready;
    logic       busy;
    logic [7:0] tx;
    logic       fa;
    logic       err;
    logic       mem_init;

    spi_reg_controller_if #(.ADDR_WIDTH(7)) bus ();

    spi_reg_controller dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_spi_data_rx  (rx),
        .i_spi_ready    (ready),
        .i_spi_busy     (busy),
        .o_spi_data_tx  (tx),
        .o_frame_active (fa),
        .o_addr_err     (err),
        .reg_bus        (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // register file model: rd_data one cycle after rd_en
    logic [7:0] mem [128];
    logic [7:0] model_mem [128];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= model_mem[i];
        end else begin
            if (bus.rd_en) bus.rd_data <= mem[bus.addr];
            if (bus.wr_en) mem[bus.addr] <= bus.wr_data;
        end
    end

    // strobe monitor
    logic [14:0] wlog [$];
    logic [6:0]  rlog [$];
    int          both_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) wlog.push_back({bus.addr, bus.wr_data});
            if (bus.rd_en) rlog.push_back(bus.addr);
            if (bus.wr_en && bus.rd_en) both_cnt++;
        end
    end

    // expected results of one frame
    logic [14:0] exp_w [$];
    logic [6:0]  exp_r [$];
    logic [7:0]  exp_tx [0:8];
    logic        exp_err;
    logic [7:0]  fdata [0:7];
    int          w_rd = 0;
    int          r_rd = 0;

    task automatic model_frame(input logic [7:0] cmd, input int n);
        int base;
        int cnt;
        int a;
        logic [7:0] rv [0:8];
        base    = int'(cmd[6:0]);
        exp_err = 1'b0;
        for (int j = 0; j <= n; j++) exp_tx[j] = IDLE;
        if (cmd[7]) begin
            for (int i = 0; i < n; i++) begin
                if (AUTOINC || i == 0) begin
                    a = (base + i) % 128;
                    if (a < RC) begin
                        exp_w.push_back({7'(a), fdata[i]});
                        model_mem[a] = fdata[i];
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end
        end else begin
            cnt = AUTOINC ? n + 1 : 1;
            for (int i = 0; i < cnt; i++) begin
                a = (base + i) % 128;
                if (a < RC) begin
                    exp_r.push_back(7'(a));
                    rv[i] = model_mem[a];
                end else begin
                    exp_err = 1'b1;
                    rv[i]   = 8'hFF;
                end
            end
            for (int j = 0; j <= n; j++) exp_tx[j] = (AUTOINC || j == 0) ? rv[j] : IDLE;
        end
    endtask

    task automatic check_logs(input string tag);
        check({tag, "_wr_cnt"}, 32'(wlog.size() - w_rd), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && (w_rd + i) < wlog.size(); i++)
            check({tag, "_wr_entry"}, 32'(wlog[w_rd + i]), 32'(exp_w[i]));
        check({tag, "_rd_cnt"}, 32'(rlog.size() - r_rd), 32'(exp_r.size()));
        for (int i = 0; i < exp_r.size() && (r_rd + i) < rlog.size(); i++)
            check({tag, "_rd_entry"}, 32'(rlog[r_rd + i]), 32'(exp_r[i]));
        w_rd = wlog.size();
        r_rd = rlog.size();
        exp_w.delete();
        exp_r.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx    = b;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic open_frame();
        @(posedge clk); #1;
        busy = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic close_frame();
        @(posedge clk); #1;
        busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input int n);
        model_frame(cmd, n);
        open_frame();
        for (int j = 0; j <= n; j++) begin
            send_byte(j == 0 ? cmd : fdata[j-1]);
            repeat (GAP) @(posedge clk);
            #1;
            check($sformatf("%s_tx_b%0d", tag, j), tx, exp_tx[j]);
        end
        check({tag, "_frame_active"}, fa, 1'b1);
        close_frame();
        check_logs(tag);
        check({tag, "_addr_err"}, err, exp_err);
        check({tag, "_tx_idle"}, tx, IDLE);
        check({tag, "_frame_idle"}, fa, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx       = 8'h00;
        ready    = 1'b0;
        busy     = 1'b0;
        mem_init = 1'b1;
        for (int i = 0; i < 128; i++) model_mem[i] = 8'($urandom);
        model_mem[3] = 8'h3C;
        #12;
        check("rst_tx", tx, IDLE);
        check("rst_addr", bus.addr, 7'h00);
        check("rst_wr_data", bus.wr_data, 8'h00);
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_rd_en", bus.rd_en, 1'b0);
        check("rst_frame_active", fa, 1'b0);
        check("rst_addr_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        mem_init = 1'b0;
        rst_n    = 1'b1;

        // write 0x05 to 0x12
        fdata[0] = 8'h05;
        run_frame("wr12", 8'h92, 1);

        // read 0x03 with exact turnaround checks
        fdata[0] = 8'h00;
        model_frame(8'h03, 1);
        open_frame();
        send_byte(8'h03);
        check("rd03_rd_en", bus.rd_en, 1'b1);
        check("rd03_addr", bus.addr, 7'h03);
        @(posedge clk); #1;
        check("rd03_tx_early", tx, IDLE);
        @(posedge clk); #1;
        check("rd03_tx_3cyc", tx, 8'h3C);
        repeat (GAP) @(posedge clk);
        send_byte(fdata[0]);
        repeat (GAP) @(posedge clk);
        #1;
        check("rd03_tx_b1", tx, exp_tx[1]);
        close_frame();
        check_logs("rd03");
        check("rd03_addr_err", err, 1'b0);

        // write burst crossing REG_COUNT
        fdata[0] = 8'hA1; fdata[1] = 8'hB2; fdata[2] = 8'hC3;
        run_frame("wr3f", 8'hBF, 3);

        // read burst across the 0x7F -> 0x00 wrap
        fdata[0] = 8'h00; fdata[1] = 8'h00;
        run_frame("rd7f", 8'h7F, 2);

        // abort right after a write command
        open_frame();
        send_byte(8'h85);
        repeat (2) @(posedge clk);
        #1;
        busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_logs("abort");
        check("abort_tx", tx, IDLE);
        check("abort_frame", fa, 1'b0);
        fdata[0] = 8'h5A;
        run_frame("post_abort", 8'h85, 1);

        // busy low and ready high together: byte dropped
        open_frame();
        send_byte(8'h90);
        repeat (3) @(posedge clk);
        #1;
        rx    = 8'hAA;
        ready = 1'b1;
        busy  = 1'b0;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_logs("busywin");
        check("busywin_tx", tx, IDLE);

        // asynchronous reset in the middle of an invalid read
        open_frame();
        send_byte(8'h50);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_tx", tx, 8'hFF);
        check("pre_rst_err", err, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_tx", tx, IDLE);
        check("arst_addr", bus.addr, 7'h00);
        check("arst_wr_data", bus.wr_data, 8'h00);
        check("arst_wr_en", bus.wr_en, 1'b0);
        check("arst_rd_en", bus.rd_en, 1'b0);
        check("arst_frame", fa, 1'b0);
        check("arst_err", err, 1'b0);
        #1;
        busy = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check_logs("arst");
        fdata[0] = 8'h00;
        run_frame("post_rst", 8'h03, 1);

        // randomized frames
        for (int k = 0; k < 24; k++) begin
            logic [7:0] cmd;
            int         n;
            cmd = {1'($urandom), 7'($urandom_range(0, 127))};
            n   = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
            run_frame($sformatf("rnd%0d", k), cmd, n);
        end

        check("rd_wr_overlap", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
